// File: rtl/npxl_frame_driver.sv
// One-wire NeoPixel frame driver: fetches LEDS pixels from a 1-cycle-latency RAM,
// scales each 8-bit channel by a global brightness and serialises MSB first.
module npxl_frame_driver #(
   parameter int LEDS         = 20,
   parameter int ADDR_W       = 8,
   parameter int BITS_PER_LED = 24,
   parameter int T0H          = 20,
   parameter int T1H          = 40,
   parameter int T_BIT        = 60,
   parameter int T_LATCH      = 3600
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_start,
   input  logic [7:0]              i_brightness,
   output logic [ADDR_W-1:0]       o_addr,
   input  logic [BITS_PER_LED-1:0] i_pixel_data,
   output logic                    o_npxl_data,
   output logic                    o_busy,
   output logic                    o_done
);

   localparam int NCH     = BITS_PER_LED / 8;
   localparam int CNT_MAX = (T_LATCH > T_BIT) ? T_LATCH : T_BIT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int BIT_W   = $clog2(BITS_PER_LED);

   localparam logic [CNT_W-1:0]  LAST_BIT_C   = CNT_W'(T_BIT - 1);
   localparam logic [CNT_W-1:0]  LAST_LATCH_C = CNT_W'(T_LATCH - 1);
   localparam logic [CNT_W-1:0]  T0H_C        = CNT_W'(T0H);
   localparam logic [CNT_W-1:0]  T1H_C        = CNT_W'(T1H);
   localparam logic [BIT_W-1:0]  MSB_IDX_C    = BIT_W'(BITS_PER_LED - 1);
   localparam logic [ADDR_W-1:0] LAST_PIX_C   = ADDR_W'(LEDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [BIT_W-1:0]        bit_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [BITS_PER_LED-1:0] shreg_q;
   logic [7:0]              bright_q;
   logic                    data_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    from_shift_q;

   logic [BITS_PER_LED-1:0] scaled_d;
   logic [15:0]             prod_d;
   logic [CNT_W-1:0]        cnt_inc_d;
   logic [CNT_W-1:0]        hi_len_d;
   logic                    line_hi_d;

   // (c * (b + 1)) >> 8 per channel; the upper product byte is the result.
   always_comb begin
      scaled_d = '0;
      prod_d   = '0;
      for (int c = 0; c < NCH; c++) begin
         prod_d = {8'd0, i_pixel_data[c*8 +: 8]} * ({8'd0, bright_q} + 16'd1);
         scaled_d[c*8 +: 8] = prod_d[15:8];
      end
   end

   // The line is registered, so its level is decided for the counter's next value.
   always_comb begin
      cnt_inc_d = cnt_q + CNT_W'(1);
      hi_len_d  = shreg_q[BITS_PER_LED-1] ? T1H_C : T0H_C;
      line_hi_d = (cnt_inc_d < hi_len_d);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= S_LATCH;
         cnt_q        <= '0;
         bit_q        <= '0;
         addr_q       <= '0;
         shreg_q      <= '0;
         bright_q     <= '0;
         data_q       <= 1'b0;
         busy_q       <= 1'b1;
         done_q       <= 1'b0;
         from_shift_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               data_q <= 1'b0;
               busy_q <= 1'b0;
               if (i_start) begin
                  bright_q <= i_brightness;
                  addr_q   <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_FETCH;
               end
            end

            S_FETCH: begin
               data_q  <= 1'b0;
               state_q <= S_LOAD;
            end

            S_LOAD: begin
               shreg_q <= scaled_d;
               bit_q   <= MSB_IDX_C;
               cnt_q   <= '0;
               data_q  <= 1'b1;
               state_q <= S_SHIFT;
            end

            S_SHIFT: begin
               if (cnt_q == LAST_BIT_C) begin
                  cnt_q <= '0;
                  if (bit_q != '0) begin
                     bit_q   <= bit_q - BIT_W'(1);
                     shreg_q <= {shreg_q[BITS_PER_LED-2:0], 1'b0};
                     data_q  <= 1'b1;
                  end else begin
                     data_q <= 1'b0;
                     if (addr_q < LAST_PIX_C) begin
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= S_FETCH;
                     end else begin
                        from_shift_q <= 1'b1;
                        state_q      <= S_LATCH;
                     end
                  end
               end else begin
                  cnt_q  <= cnt_inc_d;
                  data_q <= line_hi_d;
               end
            end

            S_LATCH: begin
               data_q <= 1'b0;
               if (cnt_q == LAST_LATCH_C) begin
                  cnt_q        <= '0;
                  busy_q       <= 1'b0;
                  done_q       <= from_shift_q;
                  from_shift_q <= 1'b0;
                  state_q      <= S_IDLE;
               end else begin
                  cnt_q <= cnt_inc_d;
               end
            end

            default: begin
               data_q  <= 1'b0;
               busy_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= S_LATCH;
            end
         endcase
      end
   end

   assign o_addr      = addr_q;
   assign o_npxl_data = data_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;

endmodule

// File: tb/tb_npxl_frame_driver.sv
// Bench for npxl_frame_driver: a 3-pixel RGB instance checked cycle by cycle against a
// waveform model, plus a 1-pixel RGBW instance checked by pulse decoding.
`timescale 1ns/1ps
module tb_npxl_frame_driver;

   localparam int LEDS    = 3;
   localparam int BPL     = 24;
   localparam int T0H     = 20;
   localparam int T1H     = 40;
   localparam int T_BIT   = 60;
   localparam int T_LATCH = 3600;

   // ---------------- clock / reset / signals ----------------
   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, start;
   logic [7:0]  bright, addr;
   logic [23:0] pix;
   logic        npxl, busy, done;

   logic        rst2, start2;
   logic [7:0]  bright2, addr2;
   logic [31:0] pix2;
   logic        npxl2, busy2, done2;
   logic        dut2_fin = 1'b0;

   logic [23:0] ram1 [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   npxl_frame_driver #(.LEDS(LEDS), .ADDR_W(8), .BITS_PER_LED(BPL), .T0H(T0H), .T1H(T1H),
                       .T_BIT(T_BIT), .T_LATCH(T_LATCH)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_brightness(bright), .o_addr(addr),
      .i_pixel_data(pix), .o_npxl_data(npxl), .o_busy(busy), .o_done(done));

   npxl_frame_driver #(.LEDS(1), .ADDR_W(8), .BITS_PER_LED(32), .T0H(T0H), .T1H(T1H),
                       .T_BIT(T_BIT), .T_LATCH(T_LATCH)) dut2 (
      .i_clk(clk), .i_rst(rst2), .i_start(start2), .i_brightness(bright2), .o_addr(addr2),
      .i_pixel_data(pix2), .o_npxl_data(npxl2), .o_busy(busy2), .o_done(done2));

   always @(posedge clk) pix  <= ram1[addr];
   always @(posedge clk) pix2 <= (addr2 == 8'd0) ? 32'hFF00FF80 : 32'h0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Entry = {line, busy, done, addr[7:0]} for one clock cycle.
   logic [10:0] exp_q[$];
   logic [10:0] last_exp = 11'h200;
   logic [10:0] cur_exp;

   function automatic logic [10:0] ent(input logic d, input logic b, input logic dn,
                                       input logic [7:0] a);
      return {d, b, dn, a};
   endfunction

   function automatic logic [23:0] scale_px(input logic [23:0] px, input logic [7:0] b);
      logic [23:0] r;
      int v;
      r = '0;
      for (int ch = 0; ch < 3; ch++) begin
         v = (int'(px[ch*8 +: 8]) * (int'(b) + 1)) / 256;
         r[ch*8 +: 8] = v[7:0];
      end
      return r;
   endfunction

   task automatic push_frame(input logic [7:0] b);
      logic [23:0] px;
      for (int p = 0; p < LEDS; p++) begin
         px = scale_px(ram1[p], b);
         exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'(p)));
         exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'(p)));
         for (int i = BPL - 1; i >= 0; i--)
            for (int c = 0; c < T_BIT; c++)
               exp_q.push_back(ent(c < (px[i] ? T1H : T0H), 1'b1, 1'b0, 8'(p)));
      end
      repeat (T_LATCH) exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'(LEDS - 1)));
      exp_q.push_back(ent(1'b0, 1'b0, 1'b1, 8'(LEDS - 1)));
   endtask

   // A frame is accepted only when the previous cycle was an idle cycle.
   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < T_LATCH - 1; i++) exp_q.push_back(ent(1'b0, 1'b1, 1'b0, 8'd0));
      end else if (exp_q.size() == 0 && last_exp[9] == 1'b0 && start) begin
         push_frame(bright);
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst) begin
         check("reset_outputs", {npxl, busy, done, addr}, ent(1'b0, 1'b1, 1'b0, 8'd0));
         last_exp = ent(1'b0, 1'b1, 1'b0, 8'd0);
      end else begin
         if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
         else cur_exp = ent(1'b0, 1'b0, 1'b0, last_exp[7:0]);
         check("cycle_outputs", {npxl, busy, done, addr}, cur_exp);
         last_exp = cur_exp;
      end
   end

   // ---------------- driver / measurement tasks ----------------
   int hi_w [0:71];
   int per_w[0:71];

   task automatic start_frame(input logic [7:0] b);
      start  = 1'b1;
      bright = b;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic count_until_idle(output int len, output int nd);
      len = 0;
      nd  = 0;
      do begin
         @(negedge clk);
         len++;
         if (done) nd++;
      end while (busy && len < 20000);
   endtask

   task automatic measure_bits(input int n);
      int g, h, l;
      g = 0;
      while (!npxl && g < 200) begin @(negedge clk); g++; end
      for (int i = 0; i < n; i++) begin
         h = 0;
         l = 0;
         while (npxl && h < 200) begin h++; @(negedge clk); end
         while (!npxl && l < 100) begin l++; @(negedge clk); end
         hi_w[i]  = h;
         per_w[i] = h + l;
      end
   endtask

   task automatic check_decode(input string tag, input logic [23:0] e0, input logic [23:0] e1,
                               input logic [23:0] e2);
      logic [23:0] w;
      logic [23:0] e [0:2];
      e[0] = e0; e[1] = e1; e[2] = e2;
      for (int p = 0; p < 3; p++) begin
         w = '0;
         for (int i = 0; i < 24; i++) w = {w[22:0], (hi_w[p*24 + i] > 30)};
         check($sformatf("%s_px%0d", tag, p), w, e[p]);
      end
   endtask

   // ---------------- main stimulus (3-pixel instance) ----------------
   initial begin
      int len, nd, g;
      logic [23:0] p0;
      rst = 1'b0; start = 1'b0; bright = 8'd0;
      for (int i = 0; i < 256; i++) ram1[i] = 24'h0;
      ram1[0] = 24'h800001;
      ram1[1] = 24'hFF8000;
      ram1[2] = 24'h000003;
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", busy, 1);
      check("reset_line", npxl, 0);
      rst = 1'b0;
      count_until_idle(len, nd);
      check("post_reset_latch_len", len, 3600);
      check("post_reset_no_done", nd, 0);
      check("model_scale_b127", scale_px(ram1[1], 8'd127), 24'h7F4000);

      // frame 1: full brightness
      start_frame(8'd255);
      check("model_frame_len", exp_q.size(), 7926);
      fork
         measure_bits(72);
         count_until_idle(len, nd);
      join
      check("f1_len", len, 7926);
      check("f1_done", nd, 1);
      p0 = 24'h800001;
      for (int i = 0; i < 24; i++) check($sformatf("f1_p0_high%0d", i), hi_w[i], p0[23-i] ? 40 : 20);
      check("f1_period0", per_w[0], 60);
      check("f1_period22", per_w[22], 60);
      check("f1_gap_p0", per_w[23], 62);
      check("f1_gap_p1", per_w[47], 62);
      check_decode("f1", 24'h800001, 24'hFF8000, 24'h000003);
      check("f1_addr_end", addr, 2);
      @(negedge clk);

      // frame 2: half brightness
      start_frame(8'd127);
      fork
         measure_bits(72);
         count_until_idle(len, nd);
      join
      check("f2_len", len, 7926);
      check_decode("f2", 24'h400000, 24'h7F4000, 24'h000001);
      @(negedge clk);

      // frame 3: zero brightness, ignored starts and brightness change mid-frame
      start_frame(8'd0);
      fork
         measure_bits(72);
         count_until_idle(len, nd);
         begin
            repeat (10) @(negedge clk);
            start = 1'b1; bright = 8'd255;
            @(negedge clk);
            start = 1'b0;
            repeat (489) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join
      check("f3_len", len, 7926);
      check("f3_single_done", nd, 1);
      check_decode("f3", 24'h0, 24'h0, 24'h0);

      // frames 4/5: start held high gives back-to-back frames
      start = 1'b1; bright = 8'd255;
      @(negedge clk);
      check("f4_accept", busy, 1);
      count_until_idle(len, nd);
      check("f4_len", len, 7926);
      @(negedge clk);
      check("b2b_accept", busy, 1);
      start = 1'b0;
      count_until_idle(len, nd);
      check("f5_len", len, 7926);
      check("f5_done", nd, 1);
      @(negedge clk);

      // frame 6: reset at bit 5 of pixel 1
      start_frame(8'd255);
      repeat (1749) @(negedge clk);
      check("pre_reset_line", npxl, 1);
      rst = 1'b1;
      #1;
      check("async_reset_line", npxl, 0);
      check("async_reset_busy", busy, 1);
      check("async_reset_done", done, 0);
      repeat (2) @(negedge clk);
      start = 1'b1;
      rst = 1'b0;
      count_until_idle(len, nd);
      check("reset_latch_len", len, 3600);
      check("reset_no_done", nd, 0);
      @(negedge clk);
      check("post_reset_accept", busy, 1);
      start = 1'b0;
      count_until_idle(len, nd);
      check("f7_len", len, 7926);
      check("f7_done", nd, 1);

      g = 0;
      while (!dut2_fin && g < 20000) begin @(negedge clk); g++; end
      check("dut2_finished", dut2_fin, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // ---------------- RGBW single-pixel instance ----------------
   initial begin
      int len2, nd2, g, h, l;
      int hi2 [0:31];
      int per2[0:31];
      logic [31:0] px;
      px = 32'hFF00FF80;
      rst2 = 1'b0; start2 = 1'b0; bright2 = 8'd0;
      #3 rst2 = 1'b1;
      repeat (2) @(negedge clk);
      rst2 = 1'b0;
      len2 = 0;
      do begin @(negedge clk); len2++; end while (busy2 && len2 < 20000);
      check("d2_post_reset_latch_len", len2, 3600);

      start2 = 1'b1; bright2 = 8'd255;
      @(negedge clk);
      start2 = 1'b0;
      fork
         begin
            g = 0;
            while (!npxl2 && g < 200) begin @(negedge clk); g++; end
            for (int i = 0; i < 32; i++) begin
               h = 0;
               l = 0;
               while (npxl2 && h < 200) begin h++; @(negedge clk); end
               while (!npxl2 && l < 100) begin l++; @(negedge clk); end
               hi2[i]  = h;
               per2[i] = h + l;
            end
         end
         begin
            len2 = 0;
            nd2  = 0;
            do begin
               @(negedge clk);
               len2++;
               if (done2) nd2++;
            end while (busy2 && len2 < 20000);
         end
      join
      check("d2_frame_len", len2, 5522);
      check("d2_done", nd2, 1);
      for (int i = 0; i < 32; i++) check($sformatf("d2_high%0d", i), hi2[i], px[31-i] ? 40 : 20);
      check("d2_period0", per2[0], 60);
      check("d2_period30", per2[30], 60);
      check("d2_addr", addr2, 0);
      dut2_fin = 1'b1;
   end

endmodule
